// File: rtl/debug_unit_ctrl_pkg.sv
// debug_pkg: shared types and constants for the UART debug sequencing controller.
//   - Command byte values decoded from the UART receiver.
//   - Default snapshot length.
//   - Mode FSM states (top) and snapshot-send FSM states (sequencer).
package debug_pkg;

    localparam logic [7:0] CMD_CONT = 8'h63;  // start continuous run
    localparam logic [7:0] CMD_STEP = 8'h73;  // enter step mode / execute one step
    localparam logic [7:0] CMD_EXIT = 8'h78;  // leave step mode

    localparam int DATA_BYTES_DEFAULT = 64;

    // Execution modes owned by the top FSM. SEND covers the whole
    // SEND_ADDR/SEND_START/SEND_WAIT loop, which lives in the sequencer.
    typedef enum logic [2:0] {
        IDLE,
        CONT,
        STEP,
        STEP_EXEC,
        SEND
    } modeState_t;

    typedef enum logic [1:0] {
        SEND_OFF,
        SEND_ADDR,
        SEND_START,
        SEND_WAIT
    } sendState_t;

endpackage

// File: rtl/debug_unit_ctrl_if.sv
// debug_unit_ctrl_if: bundle of the UART RX/TX, datapath and LED signals
// around the debug controller.
//   master: the controller (consumes rx/halt/txDone/dbgByte, drives the rest)
//   slave : the surrounding UART cores, datapath and board
interface debug_unit_ctrl_if;
    logic       rxDone;
    logic [7:0] rxData;
    logic       haltIn;
    logic       txDone;
    logic [7:0] dbgByte;
    logic       pipeEnable;
    logic [7:0] dbgAddr;
    logic       txStart;
    logic [7:0] txData;
    logic       notStartUartTx;
    logic       ledIdle;
    logic       ledStep;
    logic       ledSend;
    logic       ledCont;
    logic [7:0] sendCounter;
    logic       sentFlag;

    modport master (
        input  rxDone, rxData, haltIn, txDone, dbgByte,
        output pipeEnable, dbgAddr, txStart, txData, notStartUartTx,
               ledIdle, ledStep, ledSend, ledCont, sendCounter, sentFlag
    );

    modport slave (
        output rxDone, rxData, haltIn, txDone, dbgByte,
        input  pipeEnable, dbgAddr, txStart, txData, notStartUartTx,
               ledIdle, ledStep, ledSend, ledCont, sendCounter, sentFlag
    );
endinterface

// File: rtl/debug_unit_ctrl_tx_sequencer.sv
// debug_tx_sequencer: streams DATA_BYTES snapshot bytes out through the UART TX.
// Ports:
//   clock, resetGral      clock, async active-high reset
//   go                    one-cycle request to start a snapshot
//   dbgByte               registered snapshot mux output (valid 1 cycle after dbgAddr)
//   txDone                UART TX finished current byte
//   dbgAddr, sendCounter  current byte index
//   txStart, txData       one-cycle start pulse and byte held until txDone
//   sentFlag              one-cycle pulse after the last byte
//   done                  combinational: last byte's txDone accepted this cycle
module debug_tx_sequencer
    import debug_pkg::*;
#(
    parameter int DATA_BYTES = DATA_BYTES_DEFAULT
) (
    input  logic       clock,
    input  logic       resetGral,
    input  logic       go,
    input  logic [7:0] dbgByte,
    input  logic       txDone,
    output logic [7:0] dbgAddr,
    output logic       txStart,
    output logic [7:0] txData,
    output logic [7:0] sendCounter,
    output logic       sentFlag,
    output logic       done
);

    localparam logic [7:0] LAST_COUNT = 8'(DATA_BYTES);

    sendState_t state, stateNext;
    logic [7:0] countNext;

    assign countNext = sendCounter + 8'd1;
    // Lets the top FSM leave SEND on the same edge that raises sentFlag.
    assign done      = (state == SEND_WAIT) && txDone && (countNext == LAST_COUNT);
    assign dbgAddr   = sendCounter;

    always_comb begin
        stateNext = state;
        unique case (state)
            SEND_OFF:   if (go) stateNext = SEND_ADDR;
            SEND_ADDR:  stateNext = SEND_START;  // mux needs one cycle for dbgByte
            SEND_START: stateNext = SEND_WAIT;
            SEND_WAIT:  if (txDone) stateNext = done ? SEND_OFF : SEND_ADDR;
            default:    stateNext = SEND_OFF;
        endcase
    end

    always_ff @(posedge clock or posedge resetGral) begin
        if (resetGral) begin
            state       <= SEND_OFF;
            sendCounter <= 8'd0;
            txStart     <= 1'b0;
            txData      <= 8'd0;
            sentFlag    <= 1'b0;
        end else begin
            state    <= stateNext;
            txStart  <= (state == SEND_START);
            sentFlag <= done;
            if (state == SEND_START) txData <= dbgByte;
            if ((state == SEND_WAIT) && txDone) sendCounter <= done ? 8'd0 : countNext;
        end
    end

endmodule

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: UART debug sequencing controller.
// Decodes command bytes, gates the datapath clock-enable for continuous run or
// single-step, then hands off to debug_tx_sequencer to stream a snapshot.
// Ports:
//   clock      system clock
//   resetGral  async active-high reset
//   bus        debug_unit_ctrl_if.master (UART RX/TX, datapath, LEDs)
module debug_unit_ctrl
    import debug_pkg::*;
#(
    parameter int DATA_BYTES = DATA_BYTES_DEFAULT
) (
    input  logic                     clock,
    input  logic                     resetGral,
    debug_unit_ctrl_if.master        bus
);

    modeState_t state, stateNext;
    logic       retStep, retStepNext;  // snapshot returns to STEP (else IDLE)
    logic       pipeEnable, pipeEnableNext;
    logic       seqGo, seqDone;
    logic [7:0] seqAddr, seqTxData, seqCount;
    logic       seqTxStart, seqSent;

    always_comb begin
        stateNext   = state;
        retStepNext = retStep;
        seqGo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.rxDone) begin
                    if (bus.rxData == CMD_CONT)      stateNext = CONT;
                    else if (bus.rxData == CMD_STEP) stateNext = STEP;
                end
            end
            CONT: begin
                // halt has priority; any rx byte this cycle is dropped
                if (bus.haltIn) begin
                    stateNext   = SEND;
                    retStepNext = 1'b0;
                    seqGo       = 1'b1;
                end
            end
            STEP: begin
                if (bus.rxDone) begin
                    if (bus.rxData == CMD_STEP)      stateNext = STEP_EXEC;
                    else if (bus.rxData == CMD_EXIT) stateNext = IDLE;
                end
            end
            STEP_EXEC: begin
                stateNext   = SEND;
                retStepNext = 1'b1;
                seqGo       = 1'b1;
            end
            SEND: begin
                if (seqDone) stateNext = retStep ? STEP : IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Registered enable tracks the state being entered, so it is high
        // exactly for the cycles spent in CONT / STEP_EXEC.
        pipeEnableNext = (stateNext == CONT) || (stateNext == STEP_EXEC);
    end

    always_ff @(posedge clock or posedge resetGral) begin
        if (resetGral) begin
            state      <= IDLE;
            retStep    <= 1'b0;
            pipeEnable <= 1'b0;
        end else begin
            state      <= stateNext;
            retStep    <= retStepNext;
            pipeEnable <= pipeEnableNext;
        end
    end

    debug_tx_sequencer #(.DATA_BYTES(DATA_BYTES)) txSeq (
        .clock       (clock),
        .resetGral   (resetGral),
        .go          (seqGo),
        .dbgByte     (bus.dbgByte),
        .txDone      (bus.txDone),
        .dbgAddr     (seqAddr),
        .txStart     (seqTxStart),
        .txData      (seqTxData),
        .sendCounter (seqCount),
        .sentFlag    (seqSent),
        .done        (seqDone)
    );

    assign bus.pipeEnable     = pipeEnable;
    assign bus.dbgAddr        = seqAddr;
    assign bus.txStart        = seqTxStart;
    assign bus.notStartUartTx = ~seqTxStart;
    assign bus.txData         = seqTxData;
    assign bus.sendCounter    = seqCount;
    assign bus.sentFlag       = seqSent;
    assign bus.ledIdle        = (state == IDLE);
    assign bus.ledCont        = (state == CONT);
    assign bus.ledStep        = (state == STEP) || (state == STEP_EXEC);
    assign bus.ledSend        = (state == SEND);

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Bench for debug_unit_ctrl: dut 0 uses a 64-byte snapshot with a 3-cycle TX,
// dut 1 a 1-byte snapshot with a 1000-cycle TX.
module tb_debug_unit_ctrl;

    localparam int M_IDLE = 0, M_CONT = 1, M_STEP = 2, M_EXEC = 3, M_SEND = 4;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    logic [1:0]      rxDoneV, haltV, txDoneX;
    logic [1:0][7:0] rxDataV;
    logic [1:0]      peO, txsO, nstO, sentO, lIdle, lStep, lSend, lCont, tdO;
    logic [1:0][7:0] addrO, cntO, txdO;

    int nVec = 0, nFail = 0;
    int peCnt[2], txsCnt[2], sentCnt[2], sendCyc[2];
    logic [7:0] firstTxd[2], lastTxd[2];

    // environment's snapshot contents
    function automatic logic [7:0] memVal(input int g, input logic [7:0] a);
        if (g == 0) return 8'(int'(a) * 3 + 17);
        return a ^ 8'hA5;
    endfunction

    function automatic int nBytes(input int g);
        return (g == 0) ? 64 : 1;
    endfunction

    debug_unit_ctrl_if bus[2] ();

    for (genvar g = 0; g < 2; g++) begin : gDut
        localparam int NB  = (g == 0) ? 64 : 1;
        localparam int DLY = (g == 0) ? 3 : 1000;
        logic [7:0] byteReg;
        logic       respDone;

        assign bus[g].rxDone  = rxDoneV[g];
        assign bus[g].rxData  = rxDataV[g];
        assign bus[g].haltIn  = haltV[g];
        assign bus[g].txDone  = respDone | txDoneX[g];
        assign bus[g].dbgByte = byteReg;
        assign peO[g]   = bus[g].pipeEnable;
        assign txsO[g]  = bus[g].txStart;
        assign nstO[g]  = bus[g].notStartUartTx;
        assign sentO[g] = bus[g].sentFlag;
        assign lIdle[g] = bus[g].ledIdle;
        assign lStep[g] = bus[g].ledStep;
        assign lSend[g] = bus[g].ledSend;
        assign lCont[g] = bus[g].ledCont;
        assign addrO[g] = bus[g].dbgAddr;
        assign cntO[g]  = bus[g].sendCounter;
        assign txdO[g]  = bus[g].txData;
        assign tdO[g]   = bus[g].txDone;

        // registered snapshot mux
        always @(posedge clock) byteReg <= memVal(g, bus[g].dbgAddr);

        // UART TX model: txDone DLY cycles after txStart is seen
        initial begin : resp
            int  cnt;
            bit  pending;
            respDone = 1'b0;
            pending  = 1'b0;
            cnt      = 0;
            forever begin
                @(negedge clock);
                respDone = 1'b0;
                if (rst) pending = 1'b0;
                else if (pending) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        respDone = 1'b1;
                        pending  = 1'b0;
                    end
                end else if (bus[g].txStart) begin
                    pending = 1'b1;
                    cnt     = DLY;
                end
            end
        end

        debug_unit_ctrl #(.DATA_BYTES(NB)) dut (
            .clock     (clock),
            .resetGral (rst),
            .bus       (bus[g])
        );
    end

    // ---------------- behavioural model ----------------
    int         mMode[2], mRet[2], mIdx[2], mPh[2];
    bit         mSent[2], mTxs[2];
    logic [7:0] mTxd[2];

    initial forever begin
        @(posedge clock or posedge rst);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mMode[i] = M_IDLE; mRet[i] = M_IDLE; mIdx[i] = 0; mPh[i] = 0;
                mSent[i] = 0; mTxs[i] = 0; mTxd[i] = 8'h00;
            end else begin
                mSent[i] = 0;
                mTxs[i]  = 0;
                case (mMode[i])
                    M_IDLE: if (rxDoneV[i]) begin
                        if (rxDataV[i] == 8'h63)      mMode[i] = M_CONT;
                        else if (rxDataV[i] == 8'h73) mMode[i] = M_STEP;
                    end
                    M_CONT: if (haltV[i]) begin
                        mMode[i] = M_SEND; mRet[i] = M_IDLE; mPh[i] = 0;
                    end
                    M_STEP: if (rxDoneV[i]) begin
                        if (rxDataV[i] == 8'h73)      mMode[i] = M_EXEC;
                        else if (rxDataV[i] == 8'h78) mMode[i] = M_IDLE;
                    end
                    M_EXEC: begin
                        mMode[i] = M_SEND; mRet[i] = M_STEP; mPh[i] = 0;
                    end
                    default: begin
                        // phase 0: address issued, 1: byte arriving, 2: waiting on TX
                        if (mPh[i] == 0) mPh[i] = 1;
                        else if (mPh[i] == 1) begin
                            mPh[i] = 2; mTxs[i] = 1; mTxd[i] = memVal(i, 8'(mIdx[i]));
                        end else if (tdO[i]) begin
                            mIdx[i] = mIdx[i] + 1;
                            if (mIdx[i] == nBytes(i)) begin
                                mIdx[i] = 0; mSent[i] = 1; mMode[i] = mRet[i];
                            end else mPh[i] = 0;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [31:0] actVec(input int i);
        return {peO[i], txsO[i], nstO[i], sentO[i], lIdle[i], lStep[i], lSend[i], lCont[i],
                addrO[i], cntO[i], txdO[i]};
    endfunction

    function automatic logic [31:0] expVec(input int i);
        logic pe;
        pe = (mMode[i] == M_CONT) || (mMode[i] == M_EXEC);
        return {pe, mTxs[i], ~mTxs[i], mSent[i],
                mMode[i] == M_IDLE, (mMode[i] == M_STEP) || (mMode[i] == M_EXEC),
                mMode[i] == M_SEND, mMode[i] == M_CONT,
                8'(mIdx[i]), 8'(mIdx[i]), mTxd[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // per-cycle compare against the model, plus event tallies
    initial begin
        for (int i = 0; i < 2; i++) begin
            peCnt[i] = 0; txsCnt[i] = 0; sentCnt[i] = 0; sendCyc[i] = 0;
            firstTxd[i] = 8'h00; lastTxd[i] = 8'h00;
        end
        forever begin
            @(posedge clock);
            #2;
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "dut0 cycle outputs" : "dut1 cycle outputs", actVec(i), expVec(i));
                peCnt[i]   += int'(peO[i]);
                txsCnt[i]  += int'(txsO[i]);
                sentCnt[i] += int'(sentO[i]);
                sendCyc[i] += int'(lSend[i]);
                if (txsO[i]) begin
                    lastTxd[i] = txdO[i];
                    if (cntO[i] == 8'd0) firstTxd[i] = txdO[i];
                end
            end
        end
    end

    task automatic rx(input int i, input logic [7:0] b);
        @(negedge clock);
        rxDataV[i] = b;
        rxDoneV[i] = 1'b1;
        @(negedge clock);
        rxDoneV[i] = 1'b0;
    endtask

    task automatic waitSent(input int i, input int target);
        for (int k = 0; k < 3000 && sentCnt[i] < target; k++) @(negedge clock);
        chk("snapshot completed in budget", 32'(sentCnt[i]), 32'(target));
    endtask

    localparam logic [31:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 8'h00, 8'h00, 8'h00};

    initial begin
        int p, s, t;
        rst = 1'b1; rxDoneV = '0; haltV = '0; txDoneX = '0; rxDataV = '0;
        repeat (3) @(negedge clock);
        chk("reset state", actVec(0), RST_VEC);
        rst = 1'b0;

        // unknown byte in IDLE, stray txDone in IDLE
        rx(0, 8'h41);
        @(negedge clock);
        chk("0x41 in IDLE", {lIdle[0], peO[0]}, 2'b10);
        txDoneX[0] = 1'b1;
        @(negedge clock);
        txDoneX[0] = 1'b0;

        // continuous run, halt after 20 enable cycles
        p = peCnt[0]; t = txsCnt[0]; s = sentCnt[0];
        rx(0, 8'h63);
        repeat (19) @(negedge clock);
        haltV[0] = 1'b1;
        waitSent(0, s + 1);
        haltV[0] = 1'b0;
        @(negedge clock);
        chk("cont enable cycles", 32'(peCnt[0] - p), 32'd20);
        chk("cont txStart pulses", 32'(txsCnt[0] - t), 32'd64);
        chk("cont first byte", firstTxd[0], 8'h11);
        chk("cont last byte", lastTxd[0], 8'hCE);
        chk("cont back to idle", {lIdle[0], cntO[0]}, {1'b1, 8'h00});

        // halt already high on entry: one enable cycle
        p = peCnt[0]; s = sentCnt[0];
        haltV[0] = 1'b1;
        rx(0, 8'h63);
        waitSent(0, s + 1);
        haltV[0] = 1'b0;
        chk("pre-halted enable cycles", 32'(peCnt[0] - p), 32'd1);

        // rx and halt together in CONT: halt wins
        p = peCnt[0]; s = sentCnt[0];
        rx(0, 8'h63);
        repeat (3) @(negedge clock);
        haltV[0] = 1'b1; rxDataV[0] = 8'h73; rxDoneV[0] = 1'b1;
        @(negedge clock);
        rxDoneV[0] = 1'b0;
        waitSent(0, s + 1);
        haltV[0] = 1'b0;
        @(negedge clock);
        chk("halt beats rx", {lIdle[0], lStep[0]}, 2'b10);
        chk("halt beats rx enables", 32'(peCnt[0] - p), 32'd4);

        // step mode: unknown byte, three steps, one command dropped mid-send
        rx(0, 8'h73);
        @(negedge clock);
        chk("enter step", {lStep[0], peO[0]}, 2'b10);
        rx(0, 8'h41);
        @(negedge clock);
        chk("0x41 in STEP", {lStep[0], peO[0]}, 2'b10);
        p = peCnt[0]; s = sentCnt[0];
        for (int k = 0; k < 3; k++) begin
            rx(0, 8'h73);
            if (k == 2) begin
                repeat (20) @(negedge clock);
                rx(0, 8'h73);
            end
            waitSent(0, s + k + 1);
            @(negedge clock);
            chk("between steps", {lStep[0], peO[0]}, 2'b10);
        end
        repeat (10) @(negedge clock);
        chk("step enable pulses", 32'(peCnt[0] - p), 32'd3);
        rx(0, 8'h78);
        @(negedge clock);
        chk("exit step", lIdle[0], 1'b1);

        // reset during SEND_WAIT of byte 10
        t = txsCnt[0];
        haltV[0] = 1'b1;
        rx(0, 8'h63);
        for (int k = 0; k < 2000 && txsCnt[0] < t + 11; k++) @(negedge clock);
        chk("reached byte 10", cntO[0], 8'd10);
        s = sentCnt[0];
        #2 rst = 1'b1;
        #1 chk("async reset mid-send", actVec(0), RST_VEC);
        haltV[0] = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        repeat (5) @(negedge clock);
        chk("no sentFlag after abort", 32'(sentCnt[0]), 32'(s));

        // 1-byte snapshot with a 1000-cycle TX
        s = sendCyc[1];
        haltV[1] = 1'b1;
        rx(1, 8'h63);
        waitSent(1, 1);
        haltV[1] = 1'b0;
        @(negedge clock);
        chk("slow tx byte", firstTxd[1], 8'hA5);
        chk("slow tx single start", 32'(txsCnt[1]), 32'd1);
        chk("slow tx send cycles", 32'(sendCyc[1] - s), 32'd1003);
        chk("slow tx counter cleared", {lIdle[1], cntO[1]}, {1'b1, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
